// File: rtl/lock_pkg.sv
// Shared constants for the digit-lock input front end: button indices,
// channel widths and the command priority picker.
package lock_pkg;

    localparam int NUM_BTN                 = 4;
    localparam int SW_W                    = 8;
    localparam int BTN_RESET               = 0;
    localparam int BTN_SETTING             = 1;
    localparam int BTN_SUBMIT              = 2;
    localparam int BTN_CLR                 = 3;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Lowest index wins: reset > setting > submit > clr.
    function automatic logic [NUM_BTN-1:0] prio_pick(input logic [NUM_BTN-1:0] rise);
        prio_pick = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                prio_pick    = '0;
                prio_pick[i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/lock_debounce.sv
// Two-flop synchroniser plus whole-word debouncer: a new value is accepted
// only after DEBOUNCE_CYCLES consecutive identical mismatching samples.
module lock_debounce
    import lock_pkg::*;
#(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     s1, s2, cand;
    logic [CNT_W-1:0] cnt, cnt_base;

    // A candidate that differs from last cycle's sample starts a fresh run.
    always_comb begin
        cnt_base = cnt;
        if (s2 != cand) cnt_base = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            cand <= s2;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt_base == LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt_base + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_input_conditioner.sv
// Conditions lock buttons and switches: debounced levels, single prioritised
// command pulse per cycle, and a switch-update strobe.
module lock_input_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [SW_W-1:0]    switch_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [SW_W-1:0]    switch_stable,
    output logic               switch_changed
);

    logic [NUM_BTN-1:0] btn_level_d;
    logic [SW_W-1:0]    switch_stable_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        lock_debounce #(
            .W               (1),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn_db (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (btn_raw[i]),
            .stable  (btn_level[i])
        );
    end

    lock_debounce #(
        .W               (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sw_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (switch_raw),
        .stable  (switch_stable)
    );

    // Lower-priority rises in the same cycle are dropped, not queued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_level_d     <= '0;
            btn_pulse       <= '0;
            switch_stable_d <= '0;
        end else begin
            btn_level_d     <= btn_level;
            btn_pulse       <= prio_pick(btn_level & ~btn_level_d);
            switch_stable_d <= switch_stable;
        end
    end

    assign switch_changed = (switch_stable != switch_stable_d);

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed scenarios plus random stimulus checked each cycle against a
// sample-history model of the conditioner.
module tb_lock_input_conditioner;
    import lock_pkg::*;

    localparam int DC = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NUM_BTN-1:0] btn_raw;
    logic [SW_W-1:0]    switch_raw;
    logic [NUM_BTN-1:0] btn_level, btn_pulse;
    logic [SW_W-1:0]    switch_stable;
    logic               switch_changed;

    always #5 clk = ~clk;

    lock_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .btn_raw        (btn_raw),
        .switch_raw     (switch_raw),
        .btn_level      (btn_level),
        .btn_pulse      (btn_pulse),
        .switch_stable  (switch_stable),
        .switch_changed (switch_changed)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: raw samples per edge, newest first; the debouncer sees the
    // sample from two edges back and accepts a value once the last DC of
    // those are identical and differ from the accepted value.
    logic [11:0]        hist[$];
    logic [NUM_BTN-1:0] m_lvl, m_lvl_d, m_pulse;
    logic [SW_W-1:0]    m_sw;
    logic               m_chg;

    int edge_n;
    int npulse[NUM_BTN];
    int nchg;

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < DC + 2; j++) hist.push_back(12'h000);
        m_lvl = '0; m_lvl_d = '0; m_pulse = '0; m_sw = '0; m_chg = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic [7:0] s, input logic r);
        logic [NUM_BTN-1:0] rise;
        logic [11:0]        ref_w, w;
        logic               same;
        logic [SW_W-1:0]    old_sw;
        if (!r) begin
            model_reset();
        end else begin
            hist.push_front({s, b});
            void'(hist.pop_back());
            rise    = m_lvl & ~m_lvl_d;
            m_pulse = '0;
            for (int i = 0; i < NUM_BTN; i++)
                if (rise[i] && m_pulse == '0) m_pulse[i] = 1'b1;
            m_lvl_d = m_lvl;
            ref_w   = hist[2];
            for (int i = 0; i < NUM_BTN; i++) begin
                same = 1'b1;
                for (int j = 3; j <= DC + 1; j++) begin
                    w = hist[j];
                    if (w[i] != ref_w[i]) same = 1'b0;
                end
                if (same && ref_w[i] != m_lvl[i]) m_lvl[i] = ref_w[i];
            end
            same = 1'b1;
            for (int j = 3; j <= DC + 1; j++) begin
                w = hist[j];
                if (w[11:4] != ref_w[11:4]) same = 1'b0;
            end
            old_sw = m_sw;
            if (same && ref_w[11:4] != m_sw) m_sw = ref_w[11:4];
            m_chg = (m_sw != old_sw);
        end
    endtask

    task automatic cyc(input logic [3:0] b, input logic [7:0] s, input logic r);
        btn_raw    = b;
        switch_raw = s;
        reset_n    = r;
        @(posedge clk);
        model_step(b, s, r);
        #1;
        edge_n++;
        for (int i = 0; i < NUM_BTN; i++) if (btn_pulse[i]) npulse[i]++;
        if (switch_changed) nchg++;
        chk("level", 32'(btn_level), 32'(m_lvl));
        chk("pulse", 32'(btn_pulse), 32'(m_pulse));
        chk("sw_stable", 32'(switch_stable), 32'(m_sw));
        chk("sw_changed", 32'(switch_changed), 32'(m_chg));
        chk("pulse_onehot", 32'($countones(btn_pulse) <= 1), 32'd1);
    endtask

    task automatic clr_counts();
        edge_n = 0;
        nchg   = 0;
        for (int i = 0; i < NUM_BTN; i++) npulse[i] = 0;
    endtask

    logic [3:0] bounce_pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    int         bounce_edge;
    logic [3:0] rb;
    logic [7:0] rs;

    initial begin
        model_reset();
        clr_counts();

        // reset with everything pressed
        for (int k = 0; k < 3; k++) begin
            cyc(4'hF, 8'hFF, 1'b0);
            chk("rst_outputs", {19'd0, btn_level, btn_pulse, switch_stable, switch_changed}, 32'd0);
        end
        for (int k = 0; k < 8; k++) cyc(4'h0, 8'h00, 1'b1);

        // clean submit press
        clr_counts();
        for (int k = 1; k <= 12; k++) begin
            cyc(4'b0100, 8'h00, 1'b1);
            if (k == 5) chk("sub_level_e5", 32'(btn_level[BTN_SUBMIT]), 32'd0);
            if (k == 6) chk("sub_level_e6", 32'(btn_level[BTN_SUBMIT]), 32'd1);
            if (k == 7) chk("sub_pulse_e7", 32'(btn_pulse), 32'b0100);
        end
        chk("sub_one_pulse", 32'(npulse[BTN_SUBMIT]), 32'd1);
        for (int k = 0; k < 10; k++) cyc(4'h0, 8'h00, 1'b1);

        // bouncing setting button
        clr_counts();
        bounce_edge = 0;
        for (int k = 0; k < 17; k++) begin
            cyc((k < 9) ? (bounce_pat[k] << BTN_SETTING) : 4'b0010, 8'h00, 1'b1);
            if (btn_pulse[BTN_SETTING]) bounce_edge = edge_n;
        end
        chk("bounce_one_pulse", 32'(npulse[BTN_SETTING]), 32'd1);
        chk("bounce_pulse_edge", 32'(bounce_edge), 32'd12);
        for (int k = 0; k < 10; k++) cyc(4'h0, 8'h00, 1'b1);

        // simultaneous setting/submit/clr
        clr_counts();
        for (int k = 0; k < 12; k++) cyc(4'b1110, 8'h00, 1'b1);
        chk("simul_level", 32'(btn_level), 32'b1110);
        chk("simul_setting", 32'(npulse[BTN_SETTING]), 32'd1);
        chk("simul_others", 32'(npulse[BTN_SUBMIT] + npulse[BTN_CLR] + npulse[BTN_RESET]), 32'd0);
        for (int k = 0; k < 10; k++) cyc(4'h0, 8'h00, 1'b1);

        // switch change and short glitch
        clr_counts();
        for (int k = 1; k <= 8; k++) begin
            cyc(4'h0, 8'hA5, 1'b1);
            if (k == 5) chk("sw_e5", 32'(switch_stable), 32'h00);
            if (k == 6) chk("sw_e6", 32'({switch_stable, switch_changed}), 32'h14B);
            if (k == 7) chk("sw_chg_e7", 32'(switch_changed), 32'd0);
        end
        for (int k = 0; k < 2; k++) cyc(4'h0, 8'h5A, 1'b1);
        for (int k = 0; k < 8; k++) cyc(4'h0, 8'hA5, 1'b1);
        chk("sw_glitch_stable", 32'(switch_stable), 32'hA5);
        chk("sw_glitch_nchg", 32'(nchg), 32'd1);

        // reset in the middle of a clr count, button held through release
        clr_counts();
        for (int k = 0; k < 4; k++) cyc(4'b1000, 8'hA5, 1'b1);
        for (int k = 0; k < 2; k++) cyc(4'b1000, 8'hA5, 1'b0);
        chk("midrst_no_pulse", 32'(npulse[BTN_CLR]), 32'd0);
        clr_counts();
        for (int k = 1; k <= 12; k++) begin
            cyc(4'b1000, 8'hA5, 1'b1);
            if (k == 6) chk("midrst_none_e6", 32'(npulse[BTN_CLR]), 32'd0);
            if (k == 7) chk("midrst_pulse_e7", 32'(btn_pulse), 32'b1000);
        end
        chk("midrst_one_pulse", 32'(npulse[BTN_CLR]), 32'd1);

        // random traffic
        rb = 4'h0;
        rs = 8'h00;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) rb[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) rs = 8'($urandom);
            else if ($urandom_range(0, 7) == 0) rs ^= 8'(1 << $urandom_range(0, 7));
            cyc(rb, rs, ($urandom_range(0, 99) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_input_conditioner.md
# lock_input_conditioner

Front-end conditioning stage for the digit lock. It synchronises, debounces and edge-detects the four push-buttons (reset, setting, submit, clr) and the 8-bit switch bank, then feeds clean levels and single-cycle pulses to the lock controller. It guarantees that at most one command pulse fires per cycle, in the controller's priority order, so the controller never sees bounce or simultaneous commands.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronised cycles required before a level is accepted (10 ms at 100 MHz). Legal range is ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the debounce counter.

Ports (clock and reset first):
- `clk` input 1: system clock. This block uses one clock; there are no other clock domains inside it.
- `reset_n` input 1: reset, synchronous and active-low.
- `btn_raw` input 4: asynchronous raw buttons. Bit 0 is reset, bit 1 is setting, bit 2 is submit, bit 3 is clr.
- `switch_raw` input 8: asynchronous raw switches.
- `btn_level` output 4: debounced button levels.
- `btn_pulse` output 4: one-cycle command pulses, at most one bit set in any cycle.
- `switch_stable` output 8: debounced switch vector.
- `switch_changed` output 1: one-cycle pulse when `switch_stable` updates.

## Operation
- **Synchroniser:** every raw bit passes through 2 flops (`s1`, `s2`) before any logic uses it.
- **Debounce, per channel:** there is one counter per button and one shared counter for the 8-bit switch vector.
  - If `s2` equals the accepted value: counter ← 0.
  - Otherwise: counter ← counter + 1.
  - When the counter is at `DEBOUNCE_CYCLES-1` and a mismatch is still present: accepted value ← `s2` and counter ← 0.
  - Any return to the accepted value before the threshold restarts the count. This is how bounce is rejected.
  - The switch vector is debounced as a whole word. A change in any bit mid-count is still a mismatch, but the candidate is compared each cycle, so if `s2` changes value mid-count the counter restarts at 1.
- **Edge detect:** `rise[i]` = `btn_level[i]` & ~`btn_level_d[i]`.
- **Priority arbitration among same-cycle rises:** reset > setting > submit > clr.
  - Only the highest-priority rising bit produces a `btn_pulse`.
  - Lower-priority rises in that cycle are dropped. They are not queued.
  - Their `btn_level` still rises normally.
- **Switch update:** `switch_changed` = 1 for one cycle whenever `switch_stable` takes a new value.
- **Button falls:** falling edges produce no pulse.

## Timing
- **Reset values** (applied on any `clk` edge with `reset_n`=0): all sync flops, counters, `btn_level`, `btn_level_d`, `btn_pulse`, `switch_stable` and `switch_changed` are 0.
- **Level latency:** a raw change that holds steady shows on `btn_level` / `switch_stable` exactly 2 + `DEBOUNCE_CYCLES` clock edges after the first edge that samples it.
- **Pulse latency:** `btn_pulse` is registered. It is asserted on the edge after `btn_level` rises, i.e. 3 + `DEBOUNCE_CYCLES` edges after the raw change, and lasts exactly 1 cycle.
- **`switch_changed`:** asserted in the same cycle that `switch_stable` shows the new value.
- **Held button:** a held button gives exactly one pulse. Another pulse requires the level to fall (debounced) and then rise again.
- **`DEBOUNCE_CYCLES`=1:** the level follows `s2` after 1 mismatch cycle.
- **Reset mid-count:** the count is discarded.
- **Button held through reset release:** it is treated as a new press. It debounces, rises, and pulses once.
- **Counter overflow:** impossible. The counter is bounded by `DEBOUNCE_CYCLES-1`.

## Structure
- **Package `lock_pkg`:**
  - button index constants `BTN_RESET`=0, `BTN_SETTING`=1, `BTN_SUBMIT`=2, `BTN_CLR`=3;
  - `NUM_BTN`=4;
  - `SW_W`=8;
  - the default `DEBOUNCE_CYCLES`.
- **Sub-module `lock_debounce`:**
  - parameters `W` and `DEBOUNCE_CYCLES`;
  - contains the synchroniser, counter and accepted register;
  - instantiated 4× with `W`=1 for the buttons and 1× with `W`=8 for the switches.
- **Top level:** contains the edge detect, the priority arbiter, the pulse registers and the `switch_changed` logic.

All bench scenarios below use `DEBOUNCE_CYCLES`=4.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `btn_raw`=4'hF and `switch_raw`=8'hFF → all outputs are 0 throughout.
- **Clean press of submit:** `btn_raw[2]` goes 0→1 and is held → `btn_level[2]`=1 at edge 6, `btn_pulse`=4'b0100 only at edge 7, and no further pulses while it is held.
- **Bounce:** `btn_raw[1]` toggles 1,0,1,1,0,1,1,1,1 on successive cycles → exactly one `btn_pulse[1]`, occurring after the final stable run of 4 synchronised cycles.
- **Simultaneous press:** `btn_raw`=4'b1110 in one cycle (setting, submit, clr) → `btn_level`=4'b1110 and a single `btn_pulse`=4'b0010.
- **Switch change:** `switch_raw` 8'h00→8'hA5 and held → `switch_stable`=8'hA5 at edge 6 with `switch_changed`=1 for that one cycle. A glitch to 8'h5A lasting 2 cycles is ignored.
- **Reset mid-count:** press clr, assert `reset_n`=0 at count 2, then release with the button still held → no pulse before release, then exactly one `btn_pulse[3]` 7 edges after the first post-reset edge.
